// File: rtl/life_hud_controller.sv
// life_hud_controller: player-lives HUD sequencer.
// Holds the lives count, runs the PLAY/BLINK/OVER state machine and produces
// the sprite ROM address plus a draw enable aligned with the ROM output.
// Optional build macro LIFE_HUD_SHOW_LOST_EN adds the icon_ghost output and
// draws lost-life slots as dimmed ghosts.
module life_hud_controller #(
  parameter int unsigned MAX_LIVES    = 5,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned ICON_W       = 16,
  parameter int unsigned ICON_H       = 16,
  parameter int unsigned ICON_X0      = 16,
  parameter int unsigned ICON_Y0      = 16,
  parameter int unsigned ICON_GAP     = 4,
  parameter int unsigned BLINK_FRAMES = 60,
  parameter int unsigned BLINK_PERIOD = 8
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       new_game,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       invuln,
  output logic [7:0] icon_addr,
  output logic       icon_en
`ifdef LIFE_HUD_SHOW_LOST_EN
  ,
  output logic       icon_ghost
`endif
);

  localparam int unsigned PITCH = ICON_W + ICON_GAP;
  localparam int unsigned CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned PW    = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [2:0]    LIVES_MAX   = 3'(MAX_LIVES);
  localparam logic [2:0]    LIVES_START = 3'(START_LIVES);
  localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    PLAY,
    BLINK,
    OVER
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    lives_q, lives_d;
  logic [CW-1:0] blink_q, blink_d;
  // blink_cnt / BLINK_PERIOD parity is tracked with a frame-within-half-phase
  // counter and a toggling dark flag, so no divider is needed.
  logic [PW-1:0] phase_q, phase_d;
  logic          dark_q, dark_d;

  // State register with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= PLAY;
      lives_q <= LIVES_START;
      blink_q <= '0;
      phase_q <= '0;
      dark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      dark_q  <= dark_d;
    end
  end

  // Next-state logic: new_game beats everything, hit beats extra_life in PLAY.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    blink_d = blink_q;
    phase_d = phase_q;
    dark_d  = dark_q;
    if (new_game) begin
      state_d = PLAY;
      lives_d = LIVES_START;
      blink_d = '0;
      phase_d = '0;
      dark_d  = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (hit) begin
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              state_d = BLINK;
              blink_d = '0;
              phase_d = '0;
              dark_d  = 1'b0;
            end else begin
              lives_d = '0;
              state_d = OVER;
            end
          end else if (extra_life && (lives_q < LIVES_MAX)) begin
            lives_d = lives_q + 3'd1;
          end
        end
        BLINK: begin
          if (extra_life && (lives_q < LIVES_MAX)) begin
            lives_d = lives_q + 3'd1;
          end
          if (frame_start) begin
            if (blink_q == BLINK_LAST) begin
              state_d = PLAY;
              blink_d = '0;
              phase_d = '0;
              dark_d  = 1'b0;
            end else begin
              blink_d = blink_q + 1'b1;
              if (phase_q == PHASE_LAST) begin
                phase_d = '0;
                dark_d  = ~dark_q;
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end
          end
        end
        OVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  assign lives     = lives_q;
  assign game_over = (state_q == OVER);
  assign invuln    = (state_q == BLINK);

  logic [31:0] x32, y32, dx;
  logic        y_in, slot_c, live_c, hit_c;
  logic [2:0]  idx_c;
  logic [7:0]  addr_c;

  // Icon hit test against the precomputed left edge of every slot.
  always_comb begin
    x32    = 32'(DrawX);
    y32    = 32'(DrawY);
    y_in   = (y32 >= ICON_Y0) && (y32 < ICON_Y0 + ICON_H);
    slot_c = 1'b0;
    idx_c  = '0;
    dx     = '0;
    addr_c = '0;
    for (int unsigned i = 0; i < MAX_LIVES; i++) begin
      if ((x32 >= ICON_X0 + i * PITCH) && (x32 < ICON_X0 + i * PITCH + ICON_W)) begin
        slot_c = y_in;
        idx_c  = 3'(i);
        dx     = x32 - (ICON_X0 + i * PITCH);
      end
    end
    if (slot_c) begin
      addr_c = 8'((y32 - ICON_Y0) * ICON_W + dx);
    end
    live_c = slot_c && (idx_c < lives_q);
`ifdef LIFE_HUD_SHOW_LOST_EN
    hit_c  = slot_c;
`else
    hit_c  = live_c;
`endif
  end

  logic live_pix_q;
  logic visible;

  assign visible = (state_q == PLAY) || ((state_q == BLINK) && !dark_q);

`ifdef LIFE_HUD_SHOW_LOST_EN
  logic slot_pix_q;

  // Stage 1: register ROM address and slot/live flags for this pixel.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      icon_addr  <= '0;
      live_pix_q <= 1'b0;
      slot_pix_q <= 1'b0;
    end else begin
      icon_addr  <= hit_c ? addr_c : '0;
      live_pix_q <= live_c;
      slot_pix_q <= slot_c;
    end
  end

  // Stage 2: live icons blink, ghost slots never blink; OVER shows all ghosts.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      icon_en    <= 1'b0;
      icon_ghost <= 1'b0;
    end else if (state_q == OVER) begin
      icon_en    <= slot_pix_q;
      icon_ghost <= slot_pix_q;
    end else begin
      icon_en    <= slot_pix_q && (live_pix_q ? visible : 1'b1);
      icon_ghost <= slot_pix_q && !live_pix_q;
    end
  end
`else
  // Stage 1: register ROM address and live flag for this pixel.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      icon_addr  <= '0;
      live_pix_q <= 1'b0;
    end else begin
      icon_addr  <= hit_c ? addr_c : '0;
      live_pix_q <= live_c;
    end
  end

  // Stage 2: draw enable aligned with the ROM output, gated by blink phase.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      icon_en <= 1'b0;
    end else begin
      icon_en <= live_pix_q && visible;
    end
  end
`endif

endmodule

// File: tb/tb_life_hud_controller.sv
// Self-checking bench for life_hud_controller: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_life_hud_controller;

  localparam int MAXL  = 5;
  localparam int START = 3;
  localparam int W     = 16;
  localparam int H     = 16;
  localparam int X0    = 16;
  localparam int Y0    = 16;
  localparam int GAP   = 4;
  localparam int BF    = 60;
  localparam int BP    = 8;
  localparam int PITCH = W + GAP;

  localparam int M_PLAY  = 0;
  localparam int M_BLINK = 1;
  localparam int M_OVER  = 2;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       hit = 1'b0;
  logic       extra_life = 1'b0;
  logic       new_game = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [2:0] lives;
  logic       game_over;
  logic       invuln;
  logic [7:0] icon_addr;
  logic       icon_en;
`ifdef LIFE_HUD_SHOW_LOST_EN
  logic       icon_ghost;
`endif

  life_hud_controller #(
    .MAX_LIVES(MAXL), .START_LIVES(START), .ICON_W(W), .ICON_H(H),
    .ICON_X0(X0), .ICON_Y0(Y0), .ICON_GAP(GAP),
    .BLINK_FRAMES(BF), .BLINK_PERIOD(BP)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .hit(hit),
    .extra_life(extra_life), .new_game(new_game), .DrawX(DrawX), .DrawY(DrawY),
    .lives(lives), .game_over(game_over), .invuln(invuln),
    .icon_addr(icon_addr), .icon_en(icon_en)
`ifdef LIFE_HUD_SHOW_LOST_EN
    , .icon_ghost(icon_ghost)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Geometry from the icon rules: offset from X0, divide by the slot pitch.
  function automatic void geom(input int x, input int y, output bit in_slot,
                               output int idx, output int addr);
    int rel, off;
    in_slot = 1'b0;
    idx     = 0;
    addr    = 0;
    rel     = x - X0;
    if (rel >= 0 && y >= Y0 && y < Y0 + H) begin
      idx = rel / PITCH;
      off = rel % PITCH;
      if (off < W && idx < MAXL) begin
        in_slot = 1'b1;
        addr    = (y - Y0) * W + off;
      end
    end
  endfunction

  // Behavioural model state
  bit m_ok = 1'b0;
  int m_lives, m_mode, m_bf;
  bit s1_slot, s1_live;
  int e_addr;
  bit e_en, e_gh;

  // Model update on each active edge, using pre-edge values for the pipeline.
  always @(posedge vga_clk) begin
    bit vis, sl;
    int idx, a;
    if (reset) begin
      m_lives = START; m_mode = M_PLAY; m_bf = 0;
      s1_slot = 0; s1_live = 0; e_addr = 0; e_en = 0; e_gh = 0;
      m_ok = 1'b1;
    end else begin
      vis = (m_mode == M_PLAY) || (m_mode == M_BLINK && ((m_bf / BP) % 2 == 0));
`ifdef LIFE_HUD_SHOW_LOST_EN
      if (m_mode == M_OVER) begin
        e_en = s1_slot; e_gh = s1_slot;
      end else begin
        e_en = s1_slot && (s1_live ? vis : 1'b1);
        e_gh = s1_slot && !s1_live;
      end
`else
      e_en = s1_live && vis;
      e_gh = 1'b0;
`endif
      geom(int'(DrawX), int'(DrawY), sl, idx, a);
      s1_slot = sl;
      s1_live = sl && (idx < m_lives);
`ifdef LIFE_HUD_SHOW_LOST_EN
      e_addr = sl ? a : 0;
`else
      e_addr = s1_live ? a : 0;
`endif
      if (new_game) begin
        m_lives = START; m_mode = M_PLAY; m_bf = 0;
      end else if (m_mode == M_PLAY) begin
        if (hit) begin
          if (m_lives > 1) begin
            m_lives--; m_mode = M_BLINK; m_bf = 0;
          end else begin
            m_lives = 0; m_mode = M_OVER;
          end
        end else if (extra_life) begin
          m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
        end
      end else if (m_mode == M_BLINK) begin
        if (extra_life) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
        if (frame_start) begin
          if (m_bf == BF - 1) begin
            m_mode = M_PLAY; m_bf = 0;
          end else begin
            m_bf++;
          end
        end
      end
    end
  end

  // Compare process: every cycle on the inactive edge.
  always @(negedge vga_clk) begin
    if (m_ok) begin
      check("lives", int'(lives), m_lives);
      check("game_over", int'(game_over), int'(m_mode == M_OVER));
      check("invuln", int'(invuln), int'(m_mode == M_BLINK));
      check("icon_addr", int'(icon_addr), e_addr);
      check("icon_en", int'(icon_en), int'(e_en));
`ifdef LIFE_HUD_SHOW_LOST_EN
      check("icon_ghost", int'(icon_ghost), int'(e_gh));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1; tick(1);
      frame_start = 1'b0; tick(1);
    end
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick(2);
  endtask

  initial begin
    // Reset
    reset = 1'b1; tick(1); reset = 1'b0;
    check("rst_lives", int'(lives), 3);
    check("rst_game_over", int'(game_over), 0);
    check("rst_invuln", int'(invuln), 0);
    check("rst_icon_en", int'(icon_en), 0);

    // Geometry
    pix(16, 16);
    check("pix16_addr", int'(icon_addr), 0);
    check("pix16_en", int'(icon_en), 1);
    pix(36, 16);
    check("pix36_addr", int'(icon_addr), 0);
    check("pix36_en", int'(icon_en), 1);
    pix(33, 16);
    check("gap_en", int'(icon_en), 0);
    check("gap_addr", int'(icon_addr), 0);
    pix(17, 18);
    check("pix17_18_addr", int'(icon_addr), 33);
    pix(56, 31);
    check("icon2_en", int'(icon_en), 1);
    check("icon2_addr", int'(icon_addr), 240);
    pix(20, 32);
    check("below_en", int'(icon_en), 0);
`ifndef LIFE_HUD_SHOW_LOST_EN
    pix(76, 16);
    check("icon3_unlit_en", int'(icon_en), 0);
`endif

    // Hit, ignored second hit, blink pattern, 60-frame timeout
    DrawX = 10'd20; DrawY = 10'd20;
    hit = 1'b1; tick(1); hit = 1'b0;
    check("hit_lives", int'(lives), 2);
    check("hit_invuln", int'(invuln), 1);
    tick(4);
    hit = 1'b1; tick(1); hit = 1'b0;
    check("hit2_ignored", int'(lives), 2);
    for (int k = 0; k < BF; k++) begin
      tick(2);
      check("blink_en", int'(icon_en), (k inside {[8:15], [24:31], [40:47], [56:59]}) ? 0 : 1);
      check("blink_addr", int'(icon_addr), 68);
      frame_start = 1'b1; tick(1); frame_start = 1'b0;
      if (k == BF - 2) check("blink_last_frame", int'(invuln), 1);
      if (k == BF - 1) check("blink_done", int'(invuln), 0);
    end
    check("blink_lives", int'(lives), 2);

    // Three hits to game over, then restart
    new_game = 1'b1; tick(1); new_game = 1'b0;
    check("ng_lives", int'(lives), 3);
    for (int j = 0; j < 3; j++) begin
      hit = 1'b1; tick(1); hit = 1'b0;
      if (j < 2) frames(BF);
    end
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    check("over_invuln", int'(invuln), 0);
`ifndef LIFE_HUD_SHOW_LOST_EN
    pix(20, 20);
    check("over_en", int'(icon_en), 0);
`endif
    extra_life = 1'b1; tick(1); extra_life = 1'b0;
    check("over_extra", int'(lives), 0);
    hit = 1'b1; tick(1); hit = 1'b0;
    check("over_hit", int'(game_over), 1);
    new_game = 1'b1; tick(1); new_game = 1'b0;
    check("restart_lives", int'(lives), 3);
    check("restart_over", int'(game_over), 0);

    // Saturation and same-cycle hit + extra_life in PLAY
    repeat (4) begin
      extra_life = 1'b1; tick(1); extra_life = 1'b0; tick(1);
    end
    check("sat_lives", int'(lives), 5);
    hit = 1'b1; extra_life = 1'b1; tick(1); hit = 1'b0; extra_life = 1'b0;
    check("hit_extra_lives", int'(lives), 4);
    check("hit_extra_invuln", int'(invuln), 1);
    extra_life = 1'b1; hit = 1'b1; tick(1); extra_life = 1'b0; hit = 1'b0;
    check("blink_extra_lives", int'(lives), 5);

    // Reset mid-blink with hit high
    DrawX = 10'd20; DrawY = 10'd20;
    frames(3);
    reset = 1'b1; hit = 1'b1; tick(1); reset = 1'b0; hit = 1'b0;
    check("midrst_lives", int'(lives), 3);
    check("midrst_invuln", int'(invuln), 0);
    check("midrst_en0", int'(icon_en), 0);
    tick(1);
    check("midrst_en1", int'(icon_en), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 5000; c++) begin
      DrawX       = 10'($urandom_range(0, 139));
      DrawY       = 10'($urandom_range(0, 39));
      frame_start = ($urandom_range(0, 3) == 0);
      hit         = ($urandom_range(0, 39) == 0);
      extra_life  = ($urandom_range(0, 29) == 0);
      new_game    = ($urandom_range(0, 299) == 0);
      reset       = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    reset = 1'b0; frame_start = 1'b0; hit = 1'b0; extra_life = 1'b0; new_game = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/life_hud_controller.md
Name: life_hud_controller

Overview:
- Sequences the player-lives HUD.
- Holds the lives count and runs the hit/invulnerability-blink/game-over state machine.
- Each pixel clock, decides whether DrawX/DrawY falls inside a life icon and produces the icon-local sprite ROM address plus an aligned draw enable.
- Sits between game logic (hit/extra-life events) and the life sprite ROM/palette path, which it drives; the colour mux uses its enable.

Parameters:
- MAX_LIVES, 5: saturation limit of the lives count; must be ≤ 7.
- START_LIVES, 3: lives loaded on reset and new_game.
- ICON_W, 16: icon width in pixels; power of two.
- ICON_H, 16: icon height in pixels; ICON_W*ICON_H ≤ 256.
- ICON_X0, 16: x of the left edge of icon 0.
- ICON_Y0, 16: y of the top edge of all icons.
- ICON_GAP, 4: horizontal pixels between icons.
- BLINK_FRAMES, 60: frames of invulnerability after a hit.
- BLINK_PERIOD, 8: frames per blink half-phase.

Ports:
- vga_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- frame_start, in, 1: one-cycle pulse once per frame (start of vertical blank).
- hit, in, 1: one-cycle pulse, player damaged.
- extra_life, in, 1: one-cycle pulse, award one life.
- new_game, in, 1: one-cycle pulse, restart.
- DrawX, in, 10: current pixel x.
- DrawY, in, 10: current pixel y.
- lives, out, 3: current lives count.
- game_over, out, 1: high while in state OVER.
- invuln, out, 1: high while in state BLINK.
- icon_addr, out, 8: sprite ROM address, (DrawY-ICON_Y0)*ICON_W + (DrawX-icon_left); registered.
- icon_en, out, 1: draw enable, aligned with ROM q (one cycle after icon_addr).

Behaviour:
- Reset values (next edge with reset high):
  - lives=START_LIVES, state=PLAY, blink_cnt=0.
  - icon_addr=0, icon_en=0, game_over=0, invuln=0.
- States:
  - PLAY:
    - hit with lives>1 → lives-1, blink_cnt=0, go to BLINK.
    - hit with lives==1 → lives=0, go to OVER.
  - BLINK:
    - hit ignored.
    - blink_cnt increments on each frame_start.
    - When blink_cnt==BLINK_FRAMES-1 and frame_start → PLAY, blink_cnt=0.
  - OVER:
    - hit and extra_life ignored; lives held at 0.
- extra_life in PLAY or BLINK:
  - lives+1, saturating at MAX_LIVES.
  - Does not change state or blink_cnt.
- Same-cycle events:
  - hit and extra_life together in PLAY → hit processed, extra_life dropped.
  - hit and extra_life together in BLINK → extra_life processed.
- new_game: any state, priority over all other events.
  - Next cycle: lives=START_LIVES, state=PLAY, blink_cnt=0.
- reset asserted mid-BLINK or mid-frame → all state returns to reset values on that edge; no partial blink survives.
- Status outputs are registered:
  - lives, game_over and invuln reflect the state after the edge on which the event was sampled.
  - Event at edge N → visible after edge N.
- Icon geometry:
  - Icon i occupies x ∈ [ICON_X0 + i*(ICON_W+ICON_GAP), +ICON_W) and y ∈ [ICON_Y0, ICON_Y0+ICON_H).
  - An icon is drawn iff i < lives.
  - Gap pixels and out-of-range pixels → hit_pix=0.
- Blink visibility:
  - In BLINK, icons are visible only when (blink_cnt / BLINK_PERIOD) is even.
  - In PLAY, icons are always visible.
  - In OVER, no icons are drawn.
- Pipeline:
  - Stage 1 (edge N): icon_addr and hit_pix registered from DrawX/DrawY at N.
  - Stage 2 (edge N+1): icon_en <= hit_pix & visible.
  - icon_en therefore pairs with ROM q for the pixel at N, matching the 1-cycle synchronous ROM.
  - icon_addr is 0 whenever hit_pix=0.
- Arithmetic:
  - Subtractions are performed only after the range compare, so there is no underflow.
  - No divider: icon index is found by comparing against MAX_LIVES precomputed left edges.
- Wrap-around:
  - DrawX/DrawY wrapping back to 0 needs no special handling.
  - blink_cnt is never allowed to exceed BLINK_FRAMES-1.

Optional Feature:
- Macro: LIFE_HUD_SHOW_LOST_EN.
- Defined:
  - Adds output icon_ghost (1 bit), aligned with icon_en.
  - Slots with lives ≤ i < MAX_LIVES also assert icon_en, with icon_ghost=1, so the colour path can dim them.
  - Ghost slots do not blink.
  - In OVER, all MAX_LIVES slots are drawn as ghosts.
- Not defined:
  - No icon_ghost port.
  - Slots i ≥ lives are never drawn.

Test Plan:
- Reset with defaults → lives=3, game_over=0, invuln=0; pixel (16,16) gives icon_addr=0 and icon_en=1 two edges later; pixel (36,16) is icon 1 with icon_addr=0; pixel (33,16) is a gap pixel with icon_en=0.
- hit in PLAY with lives=3 → lives=2, invuln=1; a second hit 5 cycles later is ignored; after 60 frame_start pulses → invuln=0, state PLAY.
- During BLINK, frames 8..15 → icon_en=0 for pixel (20,20); frames 0..7 and 16..23 → icon_en=1, icon_addr=4*16+4=68.
- Three hits, each separated by a full blink → lives=0, game_over=1; later extra_life → lives stays 0; new_game → lives=3, game_over=0.
- extra_life ×4 from lives=3 → lives=5 (saturated); hit+extra_life in the same PLAY cycle → lives=4, BLINK entered.
- reset asserted mid-BLINK while hit is also high → lives=3, invuln=0, icon_en=0 on the next two edges.
